// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: recovers 8N1 UART frames from an asynchronous serial line.
// Synchronises rx, rejects start-bit glitches, samples each bit at mid-period,
// and holds the recovered byte under a valid/ack handshake.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous reset, active-low
//   rx             in   serial line, idles high, asynchronous to clk
//   info_ack       in   consumer accepts the held byte
//   received_info  out  last good byte, LSB received first
//   info_valid     out  received_info holds an unacknowledged byte
//   frame_error    out  one-cycle pulse when a stop bit samples low
//   overrun        out  unacknowledged byte was overwritten; sticky until ack
//   busy           out  a frame is in progress (state != IDLE)
module uart_byte_receiver #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       info_ack,
  output logic [7:0] received_info,
  output logic       info_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned HALF_LAST = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned BIT_LAST  = CLKS_PER_BIT - 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  logic rx_meta_q;
  logic rx_s_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;
  logic               load;

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, bit sampling and handshake logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = ST_START;
        end
      end

      // Mid start bit: a line already back high was only a glitch.
      ST_START: begin
        if (cnt_q == CNT_W'(HALF_LAST)) begin
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_W'(BIT_LAST)) begin
          shreg_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(7)) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_W'(BIT_LAST)) begin
          if (rx_s_q) begin
            load    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end

      // Hold off until a break releases so it cannot look like start bits.
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      idx_d = '0;
    end

    // A load with a simultaneous ack counts as consumed, so overrun clears.
    if (load) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      ovr_d   = valid_q && !info_ack;
    end else if (info_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign received_info = data_q;
  assign info_valid    = valid_q;
  assign frame_error   = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver at 16 clocks per bit: a frame-level model
// predicts every output each cycle, plus literal checks on key scenarios.
module tb_uart_byte_receiver;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       info_ack;
  logic [7:0] received_info;
  logic       info_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int prints   = 0;
  int fe_seen  = 0;
  bit chk_en   = 0;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .info_ack      (info_ack),
    .received_info (received_info),
    .info_valid    (info_valid),
    .frame_error   (frame_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: synchronised line, time since the start edge, expected outputs.
  bit         m_s1, m_s2;
  bit         m_active, m_wait;
  int         m_t;
  logic [7:0] m_sh;
  logic [7:0] e_info;
  bit         e_valid, e_ferr, e_ovr, e_busy;

  task automatic model_step();
    bit rs;
    bit ld;
    bit ack_eff;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_active = 1'b0; m_wait = 1'b0; m_t = 0; m_sh = 8'h00;
      e_info = 8'h00; e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    end else begin
      rs      = m_s2;
      ld      = 1'b0;
      ack_eff = info_ack && e_valid;
      e_ferr  = 1'b0;
      if (m_active) begin
        m_t = m_t + 1;
        if (m_t == H) begin
          if (rs) m_active = 1'b0;
        end else if (m_t > H && m_t < H + 9 * CPB && ((m_t - H) % CPB) == 0) begin
          m_sh[3'((m_t - H) / CPB - 1)] = rs;
        end else if (m_t == H + 9 * CPB) begin
          m_active = 1'b0;
          if (rs) ld = 1'b1;
          else begin
            e_ferr = 1'b1;
            m_wait = 1'b1;
          end
        end
      end else if (m_wait) begin
        if (rs) m_wait = 1'b0;
      end else if (!rs) begin
        m_active = 1'b1;
        m_t      = 0;
      end
      if (ld) begin
        e_ovr   = e_valid && !info_ack;
        e_valid = 1'b1;
        e_info  = m_sh;
      end else if (ack_eff) begin
        e_valid = 1'b0;
        e_ovr   = 1'b0;
      end
      e_busy = m_active || m_wait;
      m_s2 = m_s1;
      m_s1 = rx;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      if (prints < 40) begin
        prints = prints + 1;
        $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_info",  received_info,     e_info);
      check("cyc_valid", 8'(info_valid),    8'(e_valid));
      check("cyc_ferr",  8'(frame_error),   8'(e_ferr));
      check("cyc_ovr",   8'(overrun),       8'(e_ovr));
      check("cyc_busy",  8'(busy),          8'(e_busy));
    end
    if (rst_n && frame_error === 1'b1) fe_seen <= fe_seen + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first, then stop; leaves rx at the stop value.
  task automatic send(input logic [7:0] b, input bit stop, input bit ack_stop, input int ncyc);
    int bp;
    for (int c = 0; c < ncyc; c++) begin
      bp = c / CPB;
      if (bp == 0)      rx = 1'b0;
      else if (bp <= 8) rx = b[3'(bp - 1)];
      else              rx = stop;
      info_ack = ack_stop && (c == 154);
      @(negedge clk);
    end
    info_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    info_ack = 1'b1;
    @(negedge clk);
    info_ack = 1'b0;
  endtask

  initial begin
    rx = 1'b1; info_ack = 1'b0; rst_n = 1'b0;
    idle(3);
    #2 rst_n = 1'b1;
    idle(1);
    chk_en = 1'b1;

    check("rst_info",  received_info,  8'h00);
    check("rst_valid", 8'(info_valid), 8'h00);
    check("rst_ovr",   8'(overrun),    8'h00);
    check("rst_busy",  8'(busy),       8'h00);

    // Single byte
    send(8'h5A, 1'b1, 1'b0, 160);
    idle(2);
    check("byte_5a_info",  received_info,  8'h5A);
    check("byte_5a_valid", 8'(info_valid), 8'h01);
    check("byte_5a_ferr",  8'(fe_seen),    8'h00);
    ack_pulse();
    check("byte_5a_ackd", 8'(info_valid), 8'h00);

    // Glitch rejection
    rx = 1'b0; idle(4); rx = 1'b1;
    idle(20);
    check("glitch_valid", 8'(info_valid), 8'h00);
    check("glitch_busy",  8'(busy),       8'h00);
    check("glitch_ferr",  8'(fe_seen),    8'h00);

    // Framing error then break held low
    send(8'hC3, 1'b0, 1'b0, 160);
    idle(20 * CPB);
    check("ferr_pulses", 8'(fe_seen),    8'h01);
    check("ferr_info",   received_info,  8'h5A);
    check("ferr_valid",  8'(info_valid), 8'h00);
    check("ferr_busy",   8'(busy),       8'h01);
    rx = 1'b1;
    idle(5);
    check("ferr_idle", 8'(busy), 8'h00);
    send(8'h11, 1'b1, 1'b0, 160);
    idle(2);
    check("after_ferr_info",  received_info,  8'h11);
    check("after_ferr_valid", 8'(info_valid), 8'h01);
    ack_pulse();

    // Overrun
    send(8'h01, 1'b1, 1'b0, 160);
    send(8'h02, 1'b1, 1'b0, 160);
    idle(2);
    check("ovr_info",  received_info, 8'h02);
    check("ovr_flag",  8'(overrun),   8'h01);
    ack_pulse();
    check("ovr_clr",   8'(overrun),    8'h00);
    check("ovr_valid", 8'(info_valid), 8'h00);

    // Ack on the exact load cycle
    send(8'h01, 1'b1, 1'b0, 160);
    send(8'h7E, 1'b1, 1'b1, 160);
    idle(2);
    check("simul_valid", 8'(info_valid), 8'h01);
    check("simul_info",  received_info,  8'h7E);
    check("simul_ovr",   8'(overrun),    8'h00);
    ack_pulse();

    // Reset during bit 4 of 0xFF
    send(8'hFF, 1'b1, 1'b0, 5 * CPB + H);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_info",  received_info,  8'h00);
    check("midrst_valid", 8'(info_valid), 8'h00);
    check("midrst_busy",  8'(busy),       8'h00);
    check("midrst_ferr",  8'(frame_error),8'h00);
    check("midrst_ovr",   8'(overrun),    8'h00);
    rx = 1'b1;
    idle(3);
    #2 rst_n = 1'b1;
    idle(3);
    send(8'hA5, 1'b1, 1'b0, 160);
    idle(2);
    check("post_rst_info",  received_info,  8'hA5);
    check("post_rst_valid", 8'(info_valid), 8'h01);
    ack_pulse();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
